// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared types and constants for the branch redirect controller.
package brc_pkg;

  localparam int DEFAULT_PC_W = 16;

  // Execute lane indices; lane 0 always holds the older instruction.
  localparam int LANE0 = 0;
  localparam int LANE1 = 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } brc_state_t;

endpackage

// File: rtl/branch_redirect_ctrl_if.sv
// Branch-in / redirect-out signal bundle between execute, the controller and fetch.
// Handshakes: a lane is consumed on any edge where its valid and br_ready are both 1;
// a redirect is consumed on the first edge where redirect_valid and redirect_ready are both 1.
interface branch_redirect_ctrl_if #(
  parameter int PC_W = brc_pkg::DEFAULT_PC_W
);
  logic            l0_br_valid;
  logic            l0_br_taken;
  logic [PC_W-1:0] l0_br_target;
  logic            l1_br_valid;
  logic            l1_br_taken;
  logic [PC_W-1:0] l1_br_target;
  logic            br_ready;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic            redirect_ready;
  logic            squash_l1;
  logic            flush;

  modport master (
    output l0_br_valid, l0_br_taken, l0_br_target,
    output l1_br_valid, l1_br_taken, l1_br_target,
    output redirect_ready,
    input  br_ready, redirect_valid, redirect_pc, squash_l1, flush
  );

  modport slave (
    input  l0_br_valid, l0_br_taken, l0_br_target,
    input  l1_br_valid, l1_br_taken, l1_br_target,
    input  redirect_ready,
    output br_ready, redirect_valid, redirect_pc, squash_l1, flush
  );
endinterface

// File: rtl/branch_redirect_ctrl_sat_counter.sv
// Saturating up-counter that adds 0..3 per enabled cycle and sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [1:0]   inc,
  output logic [W-1:0] count
);

  logic [W:0] sum;

  assign sum = {1'b0, count} + {{(W-1){1'b0}}, inc};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (en) begin
      count <= sum[W] ? '1 : sum[W-1:0];
    end
  end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Picks the oldest taken branch of a two-lane bundle, issues one redirect to fetch,
// then holds the pipeline in flush for FLUSH_CYCLES cycles; keeps branch statistics.
module branch_redirect_ctrl
  import brc_pkg::*;
#(
  parameter int PC_W         = DEFAULT_PC_W,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  branch_redirect_ctrl_if.slave  bus,
  output logic [CNT_W-1:0]       branch_count,
  output logic [CNT_W-1:0]       taken_count,
  output brc_state_t             state_dbg
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0] FC_LOAD = FC_W'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);

  brc_state_t      state;
  logic [FC_W-1:0] fcnt;
  logic            sel_l0;
  logic            sel_l1;
  logic            take;
  logic            squash;
  logic            accept;
  logic [1:0]      br_inc;

  assign bus.br_ready = (state == IDLE);
  assign state_dbg    = state;

  always_comb begin
    sel_l0 = bus.l0_br_valid && bus.l0_br_taken;
    sel_l1 = !sel_l0 && bus.l1_br_valid && bus.l1_br_taken;
    take   = sel_l0 || sel_l1;
    // A taken older branch kills whatever lane 1 carried, taken or not.
    squash = sel_l0 && bus.l1_br_valid;
    accept = (state == IDLE) && (bus.l0_br_valid || bus.l1_br_valid);
    br_inc = {1'b0, bus.l0_br_valid} + {1'b0, bus.l1_br_valid && !squash};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state              <= IDLE;
      fcnt               <= '0;
      bus.redirect_valid <= 1'b0;
      bus.redirect_pc    <= '0;
      bus.squash_l1      <= 1'b0;
      bus.flush          <= 1'b0;
    end else begin
      bus.squash_l1 <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && take) begin
            state              <= REDIRECT;
            bus.redirect_valid <= 1'b1;
            bus.flush          <= 1'b1;
            bus.redirect_pc    <= sel_l0 ? bus.l0_br_target : bus.l1_br_target;
            bus.squash_l1      <= squash;
          end
        end
        REDIRECT: begin
          if (bus.redirect_ready) begin
            bus.redirect_valid <= 1'b0;
            if (FLUSH_CYCLES == 0) begin
              state     <= IDLE;
              bus.flush <= 1'b0;
            end else begin
              state <= FLUSH;
              fcnt  <= FC_LOAD;
            end
          end
        end
        FLUSH: begin
          if (fcnt == '0) begin
            state     <= IDLE;
            bus.flush <= 1'b0;
          end else begin
            fcnt <= fcnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_branch_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (accept),
    .inc   (br_inc),
    .count (branch_count)
  );

  sat_counter #(.W(CNT_W)) u_taken_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (accept && take),
    .inc   (2'd1),
    .count (taken_count)
  );

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Bench for branch_redirect_ctrl: vector table, corner-case sequences, and random traffic
// against a cycle-level reference model. A second instance covers CNT_W=4, FLUSH_CYCLES=0.
module tb_branch_redirect_ctrl;
  import brc_pkg::*;

  localparam int PC_W    = 16;
  localparam int FC      = 2;
  localparam int CNT_W   = 16;
  localparam int CMAX    = (1 << CNT_W) - 1;
  localparam int CNT_W_B = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  branch_redirect_ctrl_if #(.PC_W(PC_W)) bi ();
  branch_redirect_ctrl_if #(.PC_W(PC_W)) bj ();

  logic [CNT_W-1:0]   bc_a, tc_a;
  logic [CNT_W_B-1:0] bc_b, tc_b;
  brc_state_t         st_a, st_b;

  branch_redirect_ctrl #(.PC_W(PC_W), .FLUSH_CYCLES(FC), .CNT_W(CNT_W)) dut_a (
    .clk(clk), .reset(reset), .bus(bi.slave),
    .branch_count(bc_a), .taken_count(tc_a), .state_dbg(st_a)
  );

  branch_redirect_ctrl #(.PC_W(PC_W), .FLUSH_CYCLES(0), .CNT_W(CNT_W_B)) dut_b (
    .clk(clk), .reset(reset), .bus(bj.slave),
    .branch_count(bc_b), .taken_count(tc_b), .state_dbg(st_b)
  );

  int checks = 0;
  int errors = 0;

  logic [PC_W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_a(input logic l0v, input logic l0t, input logic [PC_W-1:0] t0,
                         input logic l1v, input logic l1t, input logic [PC_W-1:0] t1,
                         input logic rr);
    bi.l0_br_valid = l0v; bi.l0_br_taken = l0t; bi.l0_br_target = t0;
    bi.l1_br_valid = l1v; bi.l1_br_taken = l1t; bi.l1_br_target = t1;
    bi.redirect_ready = rr;
  endtask

  task automatic drive_b(input logic l0v, input logic l0t, input logic [PC_W-1:0] t0,
                         input logic l1v, input logic l1t, input logic [PC_W-1:0] t1,
                         input logic rr);
    bj.l0_br_valid = l0v; bj.l0_br_taken = l0t; bj.l0_br_target = t0;
    bj.l1_br_valid = l1v; bj.l1_br_taken = l1t; bj.l1_br_target = t1;
    bj.redirect_ready = rr;
  endtask

  task automatic wait_ready_a(input string name);
    int n = 0;
    while (!bi.br_ready && n < 20) begin
      tick();
      n++;
    end
    chk(name, 32'(bi.br_ready), 32'd1);
  endtask

  // Reference model: a pending redirect plus a count of flush cycles still owed.
  int              m_pend, m_left, m_bc, m_tc;
  logic [PC_W-1:0] m_pc;
  logic            m_sq;

  function automatic void model_reset();
    m_pend = 0; m_left = 0; m_bc = 0; m_tc = 0; m_pc = '0; m_sq = 1'b0;
    exp_q.delete();
  endfunction

  function automatic void model_step(input logic l0v, input logic l0t, input logic [PC_W-1:0] t0,
                                     input logic l1v, input logic l1t, input logic [PC_W-1:0] t1,
                                     input logic rr);
    int n;
    m_sq = 1'b0;
    if (m_pend == 0 && m_left == 0) begin
      n = int'(l0v) + int'(l1v && !(l0v && l0t));
      m_bc = (m_bc + n > CMAX) ? CMAX : m_bc + n;
      if (l0v && l0t) begin
        m_pend = 1; m_pc = t0; m_sq = l1v;
        m_tc = (m_tc + 1 > CMAX) ? CMAX : m_tc + 1;
        exp_q.push_back(t0);
      end else if (l1v && l1t) begin
        m_pend = 1; m_pc = t1;
        m_tc = (m_tc + 1 > CMAX) ? CMAX : m_tc + 1;
        exp_q.push_back(t1);
      end
    end else if (m_pend != 0) begin
      if (rr) begin
        m_pend = 0;
        m_left = FC;
      end
    end else begin
      m_left--;
    end
  endfunction

  typedef struct {
    logic            l0v, l0t;
    logic [PC_W-1:0] t0;
    logic            l1v, l1t;
    logic [PC_W-1:0] t1;
    logic            exp_rv;
    logic [PC_W-1:0] exp_pc;
    logic            exp_sq;
    int              exp_bc_inc;
    int              exp_tc_inc;
  } vec_t;

  vec_t vecs[8];

  int              bc0, tc0, cnt, flush_ok;
  logic            r_l0v, r_l0t, r_l1v, r_l1t, r_rr;
  logic [PC_W-1:0] r_t0, r_t1, q_pc;

  initial begin
    vecs[0] = '{1'b1, 1'b1, 16'h0040, 1'b1, 1'b1, 16'h0080, 1'b1, 16'h0040, 1'b1, 1, 1};
    vecs[1] = '{1'b1, 1'b0, 16'h0010, 1'b1, 1'b1, 16'h1234, 1'b1, 16'h1234, 1'b0, 2, 1};
    vecs[2] = '{1'b1, 1'b1, 16'h0100, 1'b0, 1'b1, 16'h0999, 1'b1, 16'h0100, 1'b0, 1, 1};
    vecs[3] = '{1'b0, 1'b1, 16'h0333, 1'b1, 1'b1, 16'h0200, 1'b1, 16'h0200, 1'b0, 1, 1};
    vecs[4] = '{1'b1, 1'b0, 16'h0444, 1'b1, 1'b0, 16'h0555, 1'b0, 16'h0000, 1'b0, 2, 0};
    vecs[5] = '{1'b1, 1'b1, 16'hfffe, 1'b1, 1'b0, 16'h0666, 1'b1, 16'hfffe, 1'b1, 1, 1};
    vecs[6] = '{1'b0, 1'b0, 16'h0777, 1'b0, 1'b1, 16'h0888, 1'b0, 16'h0000, 1'b0, 0, 0};
    vecs[7] = '{1'b0, 1'b1, 16'h5555, 1'b1, 1'b0, 16'h0aaa, 1'b0, 16'h0000, 1'b0, 1, 0};

    // Clock/reset
    reset = 1'b0;
    drive_a(0, 0, '0, 0, 0, '0, 0);
    drive_b(0, 0, '0, 0, 0, '0, 0);
    tick(); tick();
    reset = 1'b1;
    tick();
    chk("rst_br_ready", 32'(bi.br_ready), 32'd1);
    chk("rst_redirect_valid", 32'(bi.redirect_valid), 32'd0);
    chk("rst_redirect_pc", 32'(bi.redirect_pc), 32'd0);
    chk("rst_squash", 32'(bi.squash_l1), 32'd0);
    chk("rst_flush", 32'(bi.flush), 32'd0);
    chk("rst_branch_count", 32'(bc_a), 32'd0);
    chk("rst_taken_count", 32'(tc_a), 32'd0);

    // Vector table: one bundle from IDLE with fetch always ready
    foreach (vecs[i]) begin
      bc0 = int'(bc_a); tc0 = int'(tc_a);
      drive_a(vecs[i].l0v, vecs[i].l0t, vecs[i].t0, vecs[i].l1v, vecs[i].l1t, vecs[i].t1, 1'b1);
      tick();
      chk($sformatf("vec%0d_valid", i), 32'(bi.redirect_valid), 32'(vecs[i].exp_rv));
      if (vecs[i].exp_rv) chk($sformatf("vec%0d_pc", i), 32'(bi.redirect_pc), 32'(vecs[i].exp_pc));
      chk($sformatf("vec%0d_squash", i), 32'(bi.squash_l1), 32'(vecs[i].exp_sq));
      chk($sformatf("vec%0d_flush", i), 32'(bi.flush), 32'(vecs[i].exp_rv));
      chk($sformatf("vec%0d_bc", i), 32'(int'(bc_a) - bc0), 32'(vecs[i].exp_bc_inc));
      chk($sformatf("vec%0d_tc", i), 32'(int'(tc_a) - tc0), 32'(vecs[i].exp_tc_inc));
      drive_a(0, 0, '0, 0, 0, '0, 1'b1);
      tick();
      chk($sformatf("vec%0d_valid_drop", i), 32'(bi.redirect_valid), 32'd0);
      chk($sformatf("vec%0d_squash_drop", i), 32'(bi.squash_l1), 32'd0);
      wait_ready_a($sformatf("vec%0d_ready_return", i));
    end

    // Flush length: redirect cycle plus FC cycles after the handshake
    drive_a(1, 1, 16'h0040, 1, 1, 16'h0080, 1'b1);
    tick();
    drive_a(0, 0, '0, 0, 0, '0, 1'b1);
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      if (bi.flush) cnt++;
      tick();
    end
    chk("seq_flush_cycles", 32'(cnt), 32'(1 + FC));
    chk("seq_flush_ready", 32'(bi.br_ready), 32'd1);

    // Fetch stalls redirect for 3 cycles
    bc0 = int'(bc_a);
    drive_a(1, 0, 16'h0020, 1, 1, 16'h1234, 1'b0);
    tick();
    drive_a(1, 0, 16'h0020, 1, 1, 16'h1234, 1'b0);
    cnt = 0;
    for (int k = 0; k < 3; k++) begin
      if (bi.redirect_valid && bi.redirect_pc == 16'h1234 && !bi.br_ready && !bi.squash_l1) cnt++;
      tick();
    end
    if (bi.redirect_valid && bi.redirect_pc == 16'h1234 && !bi.br_ready) cnt++;
    drive_a(0, 0, '0, 0, 0, '0, 1'b1);
    tick();
    chk("stall_held_cycles", 32'(cnt), 32'd4);
    chk("stall_valid_drop", 32'(bi.redirect_valid), 32'd0);
    chk("stall_bc", 32'(int'(bc_a) - bc0), 32'd2);
    wait_ready_a("stall_ready_return");

    // Five not-taken bundles back to back
    bc0 = int'(bc_a); tc0 = int'(tc_a); flush_ok = 1;
    for (int k = 0; k < 5; k++) begin
      drive_a(1, 0, 16'(k), 1, 0, 16'(k + 8), 1'b0);
      tick();
      if (bi.flush || bi.redirect_valid) flush_ok = 0;
    end
    drive_a(0, 0, '0, 0, 0, '0, 1'b0);
    chk("nt_no_flush", 32'(flush_ok), 32'd1);
    chk("nt_bc", 32'(int'(bc_a) - bc0), 32'd10);
    chk("nt_tc", 32'(int'(tc_a) - tc0), 32'd0);

    // Bundle held by upstream during FLUSH is only counted once br_ready returns
    drive_a(1, 1, 16'h0300, 0, 0, '0, 1'b1);
    tick();
    bc0 = int'(bc_a); tc0 = int'(tc_a);
    drive_a(1, 0, 16'h0301, 1, 0, 16'h0302, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("flushhold_bc%0d", k), 32'(bc_a), 32'(bc0));
    end
    chk("flushhold_ready", 32'(bi.br_ready), 32'd1);
    tick();
    chk("flushhold_bc_after", 32'(int'(bc_a) - bc0), 32'd2);
    chk("flushhold_tc_after", 32'(int'(tc_a) - tc0), 32'd0);
    drive_a(0, 0, '0, 0, 0, '0, 1'b0);

    // Asynchronous reset in the middle of REDIRECT
    drive_a(1, 1, 16'h0abc, 1, 0, '0, 1'b0);
    tick();
    drive_a(0, 0, '0, 0, 0, '0, 1'b0);
    chk("midrst_pre_valid", 32'(bi.redirect_valid), 32'd1);
    reset = 1'b0;
    #1;
    chk("midrst_valid", 32'(bi.redirect_valid), 32'd0);
    chk("midrst_pc", 32'(bi.redirect_pc), 32'd0);
    chk("midrst_squash", 32'(bi.squash_l1), 32'd0);
    chk("midrst_flush", 32'(bi.flush), 32'd0);
    chk("midrst_bc", 32'(bc_a), 32'd0);
    chk("midrst_tc", 32'(tc_a), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("midrst_ready_after", 32'(bi.br_ready), 32'd1);
    chk("midrst_bc_after", 32'(bc_a), 32'd0);
    chk("midrst_tc_after", 32'(tc_a), 32'd0);

    // Random traffic against the reference model; counters start at 0 after the reset above
    model_reset();
    for (int c = 0; c < 400; c++) begin
      r_l0v = 1'($urandom_range(0, 1)); r_l0t = 1'($urandom_range(0, 1));
      r_l1v = 1'($urandom_range(0, 1)); r_l1t = 1'($urandom_range(0, 1));
      r_t0 = 16'($urandom); r_t1 = 16'($urandom);
      r_rr = ($urandom_range(0, 3) != 0);
      drive_a(r_l0v, r_l0t, r_t0, r_l1v, r_l1t, r_t1, r_rr);
      if (bi.redirect_valid && r_rr) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rand_handshake: got handshake on pc %0h, expected no redirect outstanding", bi.redirect_pc);
        end else begin
          q_pc = exp_q.pop_front();
          chk("rand_handshake_pc", 32'(bi.redirect_pc), 32'(q_pc));
        end
      end
      model_step(r_l0v, r_l0t, r_t0, r_l1v, r_l1t, r_t1, r_rr);
      tick();
      chk("rand_valid", 32'(bi.redirect_valid), 32'(m_pend));
      if (m_pend != 0) chk("rand_pc", 32'(bi.redirect_pc), 32'(m_pc));
      chk("rand_flush", 32'(bi.flush), 32'(m_pend != 0 || m_left > 0));
      chk("rand_ready", 32'(bi.br_ready), 32'(m_pend == 0 && m_left == 0));
      chk("rand_squash", 32'(bi.squash_l1), 32'(m_sq));
      chk("rand_bc", 32'(bc_a), 32'(m_bc));
      chk("rand_tc", 32'(tc_a), 32'(m_tc));
    end
    drive_a(0, 0, '0, 0, 0, '0, 1'b0);

    // Narrow counters saturate; zero-cycle flush returns to IDLE on the handshake
    for (int k = 0; k < 9; k++) begin
      drive_b(1, 0, 16'(k), 1, 0, 16'(k), 1'b1);
      tick();
      if (k == 6) chk("sat_bc_7", 32'(bc_b), 32'd14);
      if (k == 7) chk("sat_bc_8", 32'(bc_b), 32'd15);
    end
    chk("sat_bc_9", 32'(bc_b), 32'd15);
    chk("sat_tc", 32'(tc_b), 32'd0);
    drive_b(1, 1, 16'h0abc, 0, 0, '0, 1'b1);
    tick();
    chk("f0_valid", 32'(bj.redirect_valid), 32'd1);
    chk("f0_pc", 32'(bj.redirect_pc), 32'h0abc);
    chk("f0_ready_low", 32'(bj.br_ready), 32'd0);
    chk("f0_tc", 32'(tc_b), 32'd1);
    drive_b(0, 0, '0, 0, 0, '0, 1'b1);
    tick();
    chk("f0_valid_drop", 32'(bj.redirect_valid), 32'd0);
    chk("f0_ready_back", 32'(bj.br_ready), 32'd1);
    chk("f0_flush_low", 32'(bj.flush), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
